// File: rtl/alu_ctrl_pkg.sv
// Shared constants and FSM state type for the ALU control sequencer.
// ALU_CTRL_SEQ_MULTI_UOP_EN adds the second-uop state for jmxor.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_XOR     = 4'b1101;
  localparam logic [3:0] ALU_NOR     = 4'b1001;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_LUI     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [2:0] OP_LDST  = 3'b000;
  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_BCMP  = 3'b011;
  localparam logic [2:0] OP_RTYPE = 3'b100;

`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ISSUE2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE} state_t;
`endif

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational aluop/funct decode into the uop(s) of one instruction.
// ALU_CTRL_SEQ_MULTI_UOP_EN exposes the second uop and the multi flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4
) (
  input  logic [2:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [3:0]         uop0,
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
  output logic [3:0]         uop1,
  output logic               multi,
`endif
  output logic               illegal
);

  logic       upper_nz;
  logic [3:0] fn;

  // Only the low nibble selects the op; any set upper bit makes it illegal.
  assign upper_nz = (funct >> 4) != '0;
  assign fn       = funct[3:0];

  always_comb begin
    uop0    = ALU_ILLEGAL;
    illegal = 1'b1;
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
    uop1    = ALU_ADD;
    multi   = 1'b0;
`endif
    case (aluop)
      OP_LDST: begin uop0 = ALU_ADD; illegal = 1'b0; end
      OP_BEQ:  begin uop0 = ALU_SUB; illegal = 1'b0; end
      OP_BCMP: begin uop0 = ALU_LUI; illegal = 1'b0; end
      OP_RTYPE: begin
        if (!upper_nz) begin
          illegal = 1'b0;
          casez (fn)
            4'b0000: uop0 = ALU_ADD;
            4'b0010: uop0 = ALU_SUB;
            4'b1?1?: uop0 = ALU_SLT;
            4'b0100: uop0 = ALU_AND;
            4'b0101: uop0 = ALU_OR;
            4'b0110: uop0 = ALU_XOR;
            4'b0111: uop0 = ALU_NOR;
            4'b0011: begin
              uop0 = ALU_XOR;
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
              uop1  = ALU_ADD;
              multi = 1'b1;
`endif
            end
            default: begin
              uop0    = ALU_ILLEGAL;
              illegal = 1'b1;
            end
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered, handshaked ALU control sequencer with retired-instruction counter.
// ALU_CTRL_SEQ_MULTI_UOP_EN enables two-uop jmxor via the ISSUE2 state.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         gout,
  output logic               last,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  state_t     state_p0, state_nxt;
  logic       accept, fire;
  logic [3:0] dec_uop0;
  logic       dec_illegal;
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
  logic [3:0] dec_uop1, uop1_p0;
  logic       dec_multi, load_second;
`endif

  alu_ctrl_decode #(.FUNCT_W(FUNCT_W)) u_decode (
    .aluop   (aluop),
    .funct   (funct),
    .uop0    (dec_uop0),
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
    .uop1    (dec_uop1),
    .multi   (dec_multi),
`endif
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_p0 <= ST_IDLE;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (fire) begin
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
          if (!last) state_nxt = ST_ISSUE2;
          else
`endif
          state_nxt = accept ? ST_ISSUE : ST_IDLE;
        end
      end
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
      ST_ISSUE2: if (fire) state_nxt = accept ? ST_ISSUE : ST_IDLE;
`endif
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Accepting while the final uop drains gives zero-bubble back-to-back issue.
  always_comb begin
    out_valid = (state_p0 != ST_IDLE);
    fire      = out_valid & out_ready;
    in_ready  = (state_p0 == ST_IDLE) | (fire & last);
    accept    = in_valid & in_ready;
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
    load_second = fire & ~last;
`endif
  end

  // Output register stage: first uop on accept, second uop after the first is consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gout    <= 4'b0000;
      last    <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      gout    <= dec_uop0;
      illegal <= dec_illegal;
`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
      last    <= ~dec_multi;
    end else if (load_second) begin
      gout    <= uop1_p0;
      last    <= 1'b1;
      illegal <= 1'b0;
`else
      last    <= 1'b1;
`endif
    end
  end

`ifdef ALU_CTRL_SEQ_MULTI_UOP_EN
  always_ff @(posedge clk) begin
    if (accept) uop1_p0 <= dec_uop1;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            retired <= '0;
    else if (fire & last) retired <= retired + CNT_W'(1);
  end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked successor to the combinational ALU control decoder. Accepts one instruction class (aluop + funct) per transaction, decodes it to a 4-bit ALU control code, and, for multi-pass instructions, sequences several ALU micro-ops (uops) over consecutive cycles while back-pressuring the decode stage. Sits between instruction decode and the ALU in the multi-cycle datapath; also keeps a retired-instruction count.

## Interface
- FUNCT_W, 4: funct field width; decode uses bits [3:0], upper bits must be zero or the op is illegal.
- CNT_W, 16: width of retired-instruction counter.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  aluop/funct valid.
- in_ready  out  1  block can accept this cycle.
- aluop  in  3  op class: 000 ld/st, 001 beq/blezal, 011 branch-compare, 100 R-type; 010/101/110/111 illegal.
- funct  in  FUNCT_W  function code (R-type only).
- out_valid  out  1  gout valid.
- out_ready  in  1  ALU consumes gout.
- gout  out  4  ALU control code.
- last  out  1  current uop is final uop of instruction.
- illegal  out  1  current instruction undecodable.
- retired  out  CNT_W  count of instructions whose last uop was consumed.

## Operation
- Decode: 000→0010 add; 001→0110 sub; 011→1100. R-type funct: 0000 add 0010; 0010 sub 0110; 1x1x slt 0111; 0100 and 0000; 0101 or 0001; 0110 xor 1101; 0111 nor 1001; 0011 jmxor (see Configuration); any other funct → illegal.
- Illegal: single uop, gout=1111, illegal=1, last=1; counted in retired.
- FSM states: IDLE, ISSUE, ISSUE2.
  - IDLE: out_valid=0. Accept → ISSUE with uop0.
  - ISSUE: out_valid=1, holds uop0. On out_ready: if single-uop and new input accepted same cycle → ISSUE (new uop0); single-uop, no input → IDLE; multi-uop → ISSUE2.
  - ISSUE2: out_valid=1, gout=uop1, last=1. On out_ready: same branching as single-uop ISSUE.
- in_ready = IDLE, or (out_ready & last) in ISSUE/ISSUE2 (zero-bubble back-to-back).
- gout, last, illegal stable while out_valid & !out_ready.
- retired increments by 1 on each out_valid & out_ready & last; wraps modulo 2^CNT_W.

## Timing
- Reset values: out_valid=0, gout=0000, last=0, illegal=0, retired=0, state IDLE; in_ready=1 one cycle after reset release.
- Latency: accept at edge N → out_valid at N+1 (registered outputs, no combinational in→out path except in_ready from out_ready).
- Throughput: 1 instruction/cycle for single-uop ops; 2 cycles for 2-uop ops with out_ready held high.
- Reset asserted mid-instruction: uop sequence aborted, outputs return to reset values immediately; no partial count.
- Inputs with in_valid=0 ignored; funct ignored unless aluop=100.

## Configuration
- ALU_CTRL_SEQ_MULTI_UOP_EN defined: jmxor expands to two uops, uop0=1101 (xor, last=0), uop1=0010 (add, last=1); ISSUE2 state present.
- Not defined: jmxor is single uop 1101, last=1; ISSUE2 state and uop index logic omitted; every instruction issues in one uop.

## Structure
- Shared package alu_ctrl_pkg: 4-bit ALU control code constants (ADD, SUB, AND, OR, XOR, NOR, SLT, LUI 1100, ILLEGAL 1111), aluop class constants, FSM state typedef.
- Sub-module alu_ctrl_decode: purely combinational aluop/funct → {uop0, uop1, multi, illegal}; alu_ctrl_seq instantiates it and owns the FSM, output registers and counter.

## Test plan
- Reset: assert reset mid-ISSUE2 → out_valid=0, gout=0000, retired=0 same cycle; in_ready=1 after release.
- Back-to-back singles: aluop=100 funct 0000, 0010, 0101, 0111 with out_ready=1 → gout 0010, 0110, 0001, 1001 on consecutive cycles, last=1 each, retired=4.
- jmxor (macro on): aluop=100 funct 0011 → gout 1101 last=0, then 0010 last=1; in_ready=0 on first uop cycle; retired +1 only after second.
- jmxor (macro off): same stimulus → single gout 1101 last=1, no stall.
- Backpressure: out_ready=0 for 3 cycles on aluop=001 → gout 0110 held, in_ready=0, retired unchanged until out_ready=1.
- Illegal: aluop=100 funct 0001, then aluop=110 → gout 1111, illegal=1, last=1 each; retired +2.
